// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants and types for the byte FIFO built on
//               the 128 x 8 simple dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DATA_W       = 8;
    localparam int c_ADDR_W       = 7;
    localparam int DEPTH          = 2 ** c_ADDR_W;
    localparam int c_AF_LEVEL_DEF = 120;
    localparam int c_AE_LEVEL_DEF = 8;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [c_ADDR_W:0]   ptr_t;
    typedef logic [c_DATA_W-1:0] data_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/simple_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : simple_dual_port_ram
// Description : Simple dual-port RAM, one write port and one read port on a
//               single clock. Read data is registered (one-cycle latency) and
//               only updates when rd_en_i is high. Contents are not reset.
// Ports       : clk_i      - clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_en_i    - read strobe
//               rd_addr_i  - read address
//               rd_data_o  - read data, valid the cycle after rd_en_i
// Revision    : 1.0 - initial release
// ============================================================================
module simple_dual_port_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int c_WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_WORDS];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule : simple_dual_port_ram
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller driving a simple dual-port RAM.
//               Holds read/write pointers, occupancy count and registered
//               status flags; rejected pushes/pops raise one-cycle pulses.
// Ports       : clk_i          - clock, rising edge
//               rst_n_i        - asynchronous active-low reset
//               wr_en_i        - push request
//               wr_data_i      - push data
//               rd_en_i        - pop request
//               rd_data_o      - popped data, valid when rd_valid_o is high
//               rd_valid_o     - rd_data_o valid this cycle
//               full_o         - count_o == depth
//               empty_o        - count_o == 0
//               almost_full_o  - count_o >= AF_LEVEL
//               almost_empty_o - count_o <= AE_LEVEL
//               count_o        - occupancy, 0..depth
//               overflow_o     - pulse: push rejected because full
//               underflow_o    - pulse: pop rejected because empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int AF_LEVEL = c_AF_LEVEL_DEF,
    parameter int AE_LEVEL = c_AE_LEVEL_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] c_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_AF_CNT   = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AE_CNT   = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_af;
    logic            r_ae;
    logic            r_rd_valid;
    logic            r_ovf;
    logic            r_unf;

    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [ADDR_W:0] w_count_next;

    // Acceptance uses only the current registered flags, so a pop on empty is
    // refused even when a push lands on the same edge (no write-through), and
    // a push on full is refused even when a pop frees a slot on that edge.
    // This also guarantees the read and write addresses never collide.
    assign w_wr_ok = wr_en_i & ~r_full;
    assign w_rd_ok = rd_en_i & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_next = r_count + c_ONE;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_next = r_count - c_ONE;
        end
    end

    // Flags are computed from the next count so they line up with count_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == c_FULL_CNT);
            r_empty    <= (w_count_next == '0);
            r_af       <= (w_count_next >= c_AF_CNT);
            r_ae       <= (w_count_next <= c_AE_CNT);
            r_rd_valid <= w_rd_ok;
            r_ovf      <= wr_en_i & r_full;
            r_unf      <= rd_en_i & r_empty;
        end
    end

    simple_dual_port_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (w_wr_ok),
        .wr_addr_i (r_wr_ptr[ADDR_W-1:0]),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_rd_ok),
        .rd_addr_i (r_rd_ptr[ADDR_W-1:0]),
        .rd_data_o (rd_data_o)
    );

    assign rd_valid_o     = r_rd_valid;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_af;
    assign almost_empty_o = r_ae;
    assign count_o        = r_count;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;

endmodule : sync_fifo_ctrl
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl: a table of short
//               push/pop vectors with literal expectations, then model-driven
//               sequences (fill/overflow/drain, pointer wrap, async reset)
//               checked against a queue-based reference and a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;
    import fifo_pkg::*;

    logic       clk_i;
    logic       rst_n_i;
    logic       wr_en_i;
    data_t      wr_data_i;
    logic       rd_en_i;
    data_t      rd_data_o;
    logic       rd_valid_o;
    logic       full_o;
    logic       empty_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic [7:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    sync_fifo_ctrl u_dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .wr_en_i        (wr_en_i),
        .wr_data_i      (wr_data_i),
        .rd_en_i        (rd_en_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    data_t m_q[$];      // reference FIFO contents
    data_t exp_rd_q[$]; // scoreboard: data expected on upcoming rd_valid_o

    typedef struct {
        logic  we;
        data_t wd;
        logic  re;
        int    cnt;
        logic  emp;
        logic  ovf;
        logic  unf;
        logic  vld;
        data_t dat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus, advances the reference model, then checks
    // every output #1 after the clock edge.
    task automatic step(input logic we, input data_t wd, input logic re);
        logic m_full, m_empty, wok, rok;
        m_full  = (m_q.size() == DEPTH);
        m_empty = (m_q.size() == 0);
        wok     = we && !m_full;
        rok     = re && !m_empty;
        wr_en_i   = we;
        wr_data_i = wd;
        rd_en_i   = re;
        if (rok) exp_rd_q.push_back(m_q.pop_front());
        if (wok) m_q.push_back(wd);
        @(posedge clk_i);
        #1;
        chk("count", int'(count_o), m_q.size());
        chk("empty", int'(empty_o), int'(m_q.size() == 0));
        chk("full", int'(full_o), int'(m_q.size() == DEPTH));
        chk("almost_full", int'(almost_full_o), int'(m_q.size() >= 120));
        chk("almost_empty", int'(almost_empty_o), int'(m_q.size() <= 8));
        chk("overflow", int'(overflow_o), int'(we && m_full));
        chk("underflow", int'(underflow_o), int'(re && m_empty));
        chk("rd_valid", int'(rd_valid_o), int'(rok));
        if (rok && exp_rd_q.size() > 0) begin
            chk("rd_data", int'(rd_data_o), int'(exp_rd_q.pop_front()));
        end
    endtask

    initial begin
        // Table: push 0x45/0x22, pop twice, idle, pop-on-empty with push 0xA5,
        // pop it back, pop on empty, idle.
        vecs[0] = '{1'b1, 8'h45, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h45};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'hA5, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst_n_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        rd_en_i   = 1'b0;

        // Reset state while held in reset.
        #12;
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_almost_empty", int'(almost_empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_almost_full", int'(almost_full_o), 0);
        chk("rst_rd_valid", int'(rd_valid_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        chk("rst_underflow", int'(underflow_o), 0);

        // Release between edges, then idle: nothing spurious.
        #5 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("idle_count", int'(count_o), 0);
        chk("idle_empty", int'(empty_o), 1);
        chk("idle_rd_valid", int'(rd_valid_o), 0);
        chk("idle_underflow", int'(underflow_o), 0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            wr_en_i   = vecs[i].we;
            wr_data_i = vecs[i].wd;
            rd_en_i   = vecs[i].re;
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_count", i), int'(count_o), vecs[i].cnt);
            chk($sformatf("vec%0d_empty", i), int'(empty_o), int'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i), int'(full_o), 0);
            chk($sformatf("vec%0d_almost_empty", i), int'(almost_empty_o), 1);
            chk($sformatf("vec%0d_overflow", i), int'(overflow_o), int'(vecs[i].ovf));
            chk($sformatf("vec%0d_underflow", i), int'(underflow_o), int'(vecs[i].unf));
            chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid_o), int'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_rd_data", i), int'(rd_data_o), int'(vecs[i].dat));
            end
        end

        // Fill to 128, overflow once, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, data_t'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hEF, 1'b1);   // full: pop accepted, push rejected
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Hold count at 5 with 300 simultaneous push/pops across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, data_t'(8'h80 + i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, data_t'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

        // Async reset at count 50 with a pop just issued.
        for (int i = 0; i < 50; i++) step(1'b1, data_t'(8'h30 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        #1 rst_n_i = 1'b0;
        #1;
        chk("async_rst_count", int'(count_o), 0);
        chk("async_rst_empty", int'(empty_o), 1);
        chk("async_rst_rd_valid", int'(rd_valid_o), 0);
        #1 rst_n_i = 1'b1;
        m_q.delete();
        exp_rd_q.delete();

        // Life after reset.
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sync_fifo_ctrl
`default_nettype wire
